// File: rtl/game_pkg.sv
// Shared types and constants for the game flow sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package game_pkg;

  // HUD-visible state encoding; the numeric values are part of the overlay contract.
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_PLAY       = 3'd1,
    ST_CRASH      = 3'd2,
    ST_LEVEL_DONE = 3'd3,
    ST_GAME_OVER  = 3'd4,
    ST_WIN        = 3'd5
  } state_t;

  localparam int LIVES_W = 2;
  localparam int SCORE_W = 10;
  localparam int LVL_W   = 3;

  // Every point on the level captured; unlocks the second landing pad.
  localparam logic [4:0] ALL_POINTS = 5'b11111;

  // Score saturates here instead of wrapping.
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  // Entry guard length in PLAY cycles while GAME's pipeline flushes after reset.
  localparam logic [1:0] GUARD_CYC = 2'd2;

  // States that freeze GAME and run the dwell timer.
  function automatic logic is_hold(input state_t s);
    return (s == ST_CRASH) || (s == ST_LEVEL_DONE);
  endfunction

endpackage

// File: rtl/hold_timer.sv
// Loadable dwell down-counter shared by the CRASH and LEVEL_DONE holds.
// Latency: load at edge N reads HOLD_CYC-1 after N; done is high in the cycle the count reads 0.
// Backpressure: none; a new load restarts the count at any time.
module hold_timer #(
  parameter int HOLD_CYC = 65_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic busy,
  output logic done
);

  // At least one bit so HOLD_CYC=1 still elaborates.
  localparam int CNT_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(HOLD_CYC - 1);

  logic [CNT_W-1:0] cnt;

  // Count down from the load value; busy drops after the zero cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      busy <= 1'b0;
    end else if (load) begin
      cnt  <= LOAD_VAL;
      busy <= 1'b1;
    end else if (busy) begin
      if (cnt == '0) begin
        busy <= 1'b0;
      end else begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  assign done = busy && (cnt == '0);

endmodule

// File: rtl/game_flow_ctl.sv
// Game sequencer: lives, level progression, score and GAME reset control.
// Latency: inputs sampled at edge N update state and all (registered) outputs after edge N.
// Backpressure: none; stale GAME outputs are ignored outside PLAY and during the entry guard.
module game_flow_ctl
  import game_pkg::*;
#(
  parameter int LIVES    = 3,
  parameter int MAX_LVL  = 4,
  parameter int HOLD_CYC = 65_000_000
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic       start,
  input  logic       colission,
  input  logic       captured,
  input  logic [4:0] points,
  input  logic       landed,
  output logic [2:0] lvl,
  output logic       landing_en,
  output logic       game_rst,
  output logic [1:0] lives,
  output logic [9:0] score,
  output logic [2:0] state
);

  state_t state_q;
  state_t state_d;

  logic       start_d;
  logic       captured_d;
  logic [1:0] guard_cnt;

  logic tmr_load;
  logic tmr_busy;
  logic tmr_done;

  logic guard_on;
  logic in_play;
  logic col_ok;
  logic land_ok;
  logic cap_edge;
  logic start_edge;
  logic hold_over;

  hold_timer #(
    .HOLD_CYC (HOLD_CYC)
  ) u_hold_timer (
    .clk   (pclk),
    .rst_n (rst),
    .load  (tmr_load),
    .busy  (tmr_busy),
    .done  (tmr_done)
  );

  assign in_play    = (state_q == ST_PLAY);
  assign guard_on   = (guard_cnt != 2'd0);
  // Collision and landing only count once GAME has flushed its post-reset pipeline.
  assign col_ok     = in_play && colission && !guard_on;
  assign land_ok    = in_play && landed && landing_en && !guard_on;
  assign cap_edge   = captured && !captured_d;
  assign start_edge = start && !start_d;
  // An idle timer inside a hold state can only mean the hold is over; never stall there.
  assign hold_over  = tmr_done || (is_hold(state_q) && !tmr_busy);

  // State register.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode; collision is checked before landing so it wins a tie.
  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (col_ok) begin
          state_d  = ST_CRASH;
          tmr_load = 1'b1;
        end else if (land_ok) begin
          state_d  = ST_LEVEL_DONE;
          tmr_load = 1'b1;
        end
      end
      ST_CRASH: begin
        if (hold_over) begin
          state_d = (lives == '0) ? ST_GAME_OVER : ST_PLAY;
        end
      end
      ST_LEVEL_DONE: begin
        if (hold_over) begin
          state_d = (lvl == LVL_W'(MAX_LVL)) ? ST_WIN : ST_PLAY;
        end
      end
      ST_GAME_OVER, ST_WIN: begin
        if (start_edge) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // GAME is held in reset in every state except PLAY, aligned with the state register.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      game_rst   <= 1'b1;
      landing_en <= 1'b0;
    end else begin
      game_rst   <= (state_d != ST_PLAY);
      landing_en <= (state_d == ST_PLAY) && (points == ALL_POINTS);
    end
  end

  // Lives reload whenever we head to IDLE and drop by one on each crash, floored at 0.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      lives <= LIVES_W'(LIVES);
    end else if (state_d == ST_IDLE) begin
      lives <= LIVES_W'(LIVES);
    end else if (in_play && (state_d == ST_CRASH) && (lives != '0)) begin
      lives <= lives - LIVES_W'(1);
    end
  end

  // Level resets with IDLE and advances only when a level hold hands back to PLAY.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      lvl <= '0;
    end else if (state_d == ST_IDLE) begin
      lvl <= '0;
    end else if ((state_q == ST_LEVEL_DONE) && (state_d == ST_PLAY)) begin
      lvl <= lvl + LVL_W'(1);
    end
  end

  // Score counts capture rising edges in PLAY, saturating; cleared when a new game starts.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      score <= '0;
    end else if ((state_q == ST_IDLE) && (state_d == ST_PLAY)) begin
      score <= '0;
    end else if (in_play && cap_edge && (score != SCORE_MAX)) begin
      score <= score + SCORE_W'(1);
    end
  end

  // Entry guard: armed on every PLAY entry, runs down during the first PLAY cycles.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      guard_cnt <= 2'd0;
    end else if ((state_d == ST_PLAY) && !in_play) begin
      guard_cnt <= GUARD_CYC;
    end else if (in_play && guard_on) begin
      guard_cnt <= guard_cnt - 2'd1;
    end
  end

  // Edge-detect history tracks the inputs continuously so stale levels never look like new edges.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      start_d    <= 1'b0;
      captured_d <= 1'b0;
    end else begin
      start_d    <= start;
      captured_d <= captured;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_game_flow_ctl.sv
// Directed bench for game_flow_ctl with HOLD_CYC=8 and a queue of expected post-edge snapshots.
module tb_game_flow_ctl;
  import game_pkg::*;

  logic       pclk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       colission = 1'b0;
  logic       captured = 1'b0;
  logic [4:0] points = 5'd0;
  logic       landed = 1'b0;
  logic [2:0] lvl;
  logic       landing_en;
  logic       game_rst;
  logic [1:0] lives;
  logic [9:0] score;
  logic [2:0] state;

  always #5 pclk = ~pclk;

  game_flow_ctl #(
    .LIVES    (3),
    .MAX_LVL  (4),
    .HOLD_CYC (8)
  ) dut (
    .pclk       (pclk),
    .rst        (rst),
    .start      (start),
    .colission  (colission),
    .captured   (captured),
    .points     (points),
    .landed     (landed),
    .lvl        (lvl),
    .landing_en (landing_en),
    .game_rst   (game_rst),
    .lives      (lives),
    .score      (score),
    .state      (state)
  );

  typedef struct {
    logic [2:0] st;
    logic [1:0] lives;
    logic [2:0] lvl;
    logic [9:0] score;
    logic       chk_score;
    logic       grst;
    logic       len;
  } exp_t;

  exp_t  sb[$];
  string sb_tag[$];

  int errors = 0;
  int checks = 0;

  logic [1:0] e_lives;
  logic [2:0] e_lvl;
  logic [9:0] e_score;
  logic       e_len;
  logic       e_chk_score;

  task automatic cmp(input string tag, input string fld, input logic [9:0] obs, input logic [9:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s.%s observed=%0d expected=%0d", tag, fld, obs, req);
    end
  endtask

  task automatic push(input string tag, input logic [2:0] st, input logic grst);
    exp_t e;
    e.st        = st;
    e.lives     = e_lives;
    e.lvl       = e_lvl;
    e.score     = e_score;
    e.chk_score = e_chk_score;
    e.grst      = grst;
    e.len       = e_len;
    sb.push_back(e);
    sb_tag.push_back(tag);
  endtask

  task automatic check_front();
    exp_t  e;
    string t;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL sb_empty observed=0 expected=nonzero");
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      t = sb_tag.pop_front();
      cmp(t, "state",      10'(state),      10'(e.st));
      cmp(t, "lives",      10'(lives),      10'(e.lives));
      cmp(t, "lvl",        10'(lvl),        10'(e.lvl));
      cmp(t, "game_rst",   10'(game_rst),   10'(e.grst));
      cmp(t, "landing_en", 10'(landing_en), 10'(e.len));
      if (e.chk_score) cmp(t, "score", score, e.score);
    end
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
    check_front();
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic play_guard();
    repeat (2) begin
      push("guard", ST_PLAY, 1'b0);
      step();
    end
  endtask

  // Remaining 7 hold cycles; capture toggles here must not score.
  task automatic do_hold(input string tag, input logic [2:0] hst);
    for (int i = 1; i < 8; i++) begin
      captured = ~captured;
      push(tag, hst, 1'b1);
      step();
    end
    captured = 1'b0;
  endtask

  task automatic crash(input string tag, input logic with_landed);
    colission = 1'b1;
    landed    = with_landed;
    points    = 5'd0;
    if (e_lives != 2'd0) e_lives = e_lives - 2'd1;
    e_len = 1'b0;
    push(tag, ST_CRASH, 1'b1);
    step();
    colission = 1'b0;
    landed    = 1'b0;
    do_hold(tag, ST_CRASH);
    if (e_lives == 2'd0) push(tag, ST_GAME_OVER, 1'b1);
    else                 push(tag, ST_PLAY, 1'b0);
    step();
  endtask

  task automatic level_done(input string tag);
    points = 5'b11111;
    e_len  = 1'b1;
    push(tag, ST_PLAY, 1'b0);
    step();
    landed = 1'b1;
    points = 5'd0;
    e_len  = 1'b0;
    push(tag, ST_LEVEL_DONE, 1'b1);
    step();
    landed = 1'b0;
    do_hold(tag, ST_LEVEL_DONE);
    if (e_lvl == 3'd4) begin
      push(tag, ST_WIN, 1'b1);
    end else begin
      e_lvl = e_lvl + 3'd1;
      push(tag, ST_PLAY, 1'b0);
    end
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    e_lives     = 2'd3;
    e_lvl       = 3'd0;
    e_score     = 10'd0;
    e_len       = 1'b0;
    e_chk_score = 1'b1;

    // Reset state, observed asynchronously before any clock edge.
    #1 rst = 1'b0;
    #2;
    push("reset", ST_IDLE, 1'b1);
    check_front();
    repeat (2) @(posedge pclk);
    @(negedge pclk) rst = 1'b1;
    push("idle", ST_IDLE, 1'b1);
    step();

    // Start, then a collision inside the entry guard is ignored.
    start = 1'b1;
    push("start", ST_PLAY, 1'b0);
    step();
    start = 1'b0;
    colission = 1'b1;
    push("guard_first", ST_PLAY, 1'b0);
    step();
    colission = 1'b0;
    push("guard_second", ST_PLAY, 1'b0);
    step();

    // Five capture edges, then a held capture counts once.
    for (int i = 0; i < 5; i++) begin
      captured = 1'b1;
      e_score  = e_score + 10'd1;
      push("score_edge", ST_PLAY, 1'b0);
      step();
      captured = 1'b0;
      push("score_low", ST_PLAY, 1'b0);
      step();
    end
    captured = 1'b1;
    e_score  = e_score + 10'd1;
    repeat (4) begin
      push("score_hold", ST_PLAY, 1'b0);
      step();
    end
    captured = 1'b0;
    push("score_hold", ST_PLAY, 1'b0);
    step();

    // Collision with an 8-cycle hold; captures during CRASH do not score.
    crash("crash1", 1'b0);

    // Collision on the first PLAY cycle after a crash is masked.
    colission = 1'b1;
    push("guard_after_crash", ST_PLAY, 1'b0);
    step();
    colission = 1'b0;
    push("guard_after_crash", ST_PLAY, 1'b0);
    step();

    // Collision beats landing when both arrive with the pad enabled.
    points = 5'b11111;
    e_len  = 1'b1;
    push("len_on", ST_PLAY, 1'b0);
    step();
    crash("prio", 1'b1);
    play_guard();

    // Complete levels 0..4; the last one wins.
    for (int k = 0; k < 5; k++) begin
      level_done("level");
      if (k < 4) play_guard();
    end

    // WIN leaves on a start edge; start still high then begins a new game.
    push("win_hold", ST_WIN, 1'b1);
    step();
    start       = 1'b1;
    e_lives     = 2'd3;
    e_lvl       = 3'd0;
    e_chk_score = 1'b0;
    push("win_exit", ST_IDLE, 1'b1);
    step();
    e_score     = 10'd0;
    e_chk_score = 1'b1;
    push("restart", ST_PLAY, 1'b0);
    step();
    start = 1'b0;
    play_guard();

    // Saturation after more than 1023 capture edges.
    for (int i = 0; i < 1030; i++) begin
      captured = 1'b1;
      tick();
      captured = 1'b0;
      tick();
    end
    e_score = 10'd1023;
    push("score_sat", ST_PLAY, 1'b0);
    step();

    // Lose all lives; start held across the final hold must not retrigger.
    crash("co1", 1'b0);
    play_guard();
    crash("co2", 1'b0);
    play_guard();
    start = 1'b1;
    crash("co3", 1'b0);
    push("go_held", ST_GAME_OVER, 1'b1);
    step();
    push("go_held", ST_GAME_OVER, 1'b1);
    step();
    start = 1'b0;
    push("go_low", ST_GAME_OVER, 1'b1);
    step();
    start       = 1'b1;
    e_lives     = 2'd3;
    e_lvl       = 3'd0;
    e_chk_score = 1'b0;
    push("go_exit", ST_IDLE, 1'b1);
    step();
    start = 1'b0;
    push("go_idle", ST_IDLE, 1'b1);
    step();

    // Asynchronous reset in the middle of a crash hold.
    start       = 1'b1;
    e_score     = 10'd0;
    e_chk_score = 1'b1;
    push("play3", ST_PLAY, 1'b0);
    step();
    start = 1'b0;
    play_guard();
    colission = 1'b1;
    e_lives   = 2'd2;
    push("crash_pre_rst", ST_CRASH, 1'b1);
    step();
    colission = 1'b0;
    push("crash_pre_rst", ST_CRASH, 1'b1);
    step();
    rst = 1'b0;
    #1;
    e_lives = 2'd3;
    e_lvl   = 3'd0;
    push("async_rst", ST_IDLE, 1'b1);
    check_front();
    @(negedge pclk) rst = 1'b1;
    push("post_rst", ST_IDLE, 1'b1);
    step();

    // A fresh hold after the reset still lasts exactly 8 cycles.
    start = 1'b1;
    push("play4", ST_PLAY, 1'b0);
    step();
    start = 1'b0;
    play_guard();
    crash("after_rst", 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
